// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU
// operation selects, mux selects, FSM state codes and the strobe bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_e;

    // Control strobes driven into the datapath, one field per output port.
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control strobe decode for the multi-cycle FSM.
// Only FETCH looks at mem_ready, to hold IR/PC loads until the fetch lands.
module mc_output_decode
    import mips_pkg::*;
(
    input  logic              i_reset,
    input  logic [3:0]        i_state,
    input  logic              i_mem_ready,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_c;

    // Everything defaults low; each state raises only the strobes it needs.
    always_comb begin
        w_c = '0;
        if (!i_reset) begin
            case (i_state)
                S_FETCH: begin
                    w_c.memread = 1'b1;
                    w_c.iord    = 1'b0;
                    if (i_mem_ready) begin
                        w_c.irwrite = 1'b1;
                        w_c.alusrca = 1'b0;
                        w_c.alusrcb = SRCB_FOUR;
                        w_c.aluop   = ALUOP_ADD;
                        w_c.pcsrc   = PCSRC_ALU;
                        w_c.pcwrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    w_c.alusrca = 1'b0;
                    w_c.alusrcb = SRCB_IMMSH;
                    w_c.aluop   = ALUOP_ADD;
                end
                S_MEMADR: begin
                    w_c.alusrca = 1'b1;
                    w_c.alusrcb = SRCB_IMM;
                    w_c.aluop   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    w_c.memread = 1'b1;
                    w_c.iord    = 1'b1;
                end
                S_MEMWB: begin
                    w_c.regdst   = 1'b0;
                    w_c.memtoreg = 1'b1;
                    w_c.regwrite = 1'b1;
                end
                S_MEMWR: begin
                    w_c.memwrite = 1'b1;
                    w_c.iord     = 1'b1;
                end
                S_EXEC: begin
                    w_c.alusrca = 1'b1;
                    w_c.alusrcb = SRCB_REGB;
                    w_c.aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    w_c.regdst   = 1'b1;
                    w_c.memtoreg = 1'b0;
                    w_c.regwrite = 1'b1;
                end
                S_BRANCH: begin
                    w_c.alusrca     = 1'b1;
                    w_c.alusrcb     = SRCB_REGB;
                    w_c.aluop       = ALUOP_SUB;
                    w_c.pcwritecond = 1'b1;
                    w_c.pcsrc       = PCSRC_ALUOUT;
                end
                S_ADDIEX: begin
                    w_c.alusrca = 1'b1;
                    w_c.alusrcb = SRCB_IMM;
                    w_c.aluop   = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    w_c.regdst   = 1'b0;
                    w_c.memtoreg = 1'b0;
                    w_c.regwrite = 1'b1;
                end
                S_JUMP: begin
                    w_c.pcwrite = 1'b1;
                    w_c.pcsrc   = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign o_ctrl = w_c;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: Moore FSM sharing one memory port between
// fetch and data access, with wait-state timeout, retire counter and trap.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOP,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_e            r_state;
    state_e            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retired;
    logic              r_halted;
    logic              r_bus_err;
    logic              w_mem_state;
    logic              w_timeout;
    logic              w_retire;
    logic [CTRL_W-1:0] w_ctrl_bits;
    ctrl_t             w_ctrl;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    // The wait that would be the MAX_WAIT-th stalled cycle aborts the access;
    // a ready arriving on that same cycle still wins.
    assign w_timeout   = w_mem_state && !mem_ready &&
                         (r_wait == WAIT_W'(MAX_WAIT - 1));

    // Next-state selection; the timeout overrides whatever the state chose.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
        if (w_timeout) w_next = S_TRAP;
    end

    // Only the final state of a legal instruction returning to FETCH retires.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_MEMWB, S_MEMWR, S_ALUWB,
                                       S_BRANCH, S_ADDIWB, S_JUMP});

    // State register, wait counter, retire counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !mem_ready && (w_next == r_state))
                r_wait <= r_wait + WAIT_W'(1);
            else
                r_wait <= '0;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
            if (w_next == S_TRAP)
                r_halted <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    mc_output_decode u_dec (
        .i_reset     (reset),
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl_bits)
    );

    assign w_ctrl      = ctrl_t'(w_ctrl_bits);
    assign IorD        = w_ctrl.iord;
    assign IRWrite     = w_ctrl.irwrite;
    assign PCWrite     = w_ctrl.pcwrite;
    assign PCWriteCond = w_ctrl.pcwritecond;
    assign PCSrc       = w_ctrl.pcsrc;
    assign ALUSrcA     = w_ctrl.alusrca;
    assign ALUSrcB     = w_ctrl.alusrcb;
    assign ALUOP       = w_ctrl.aluop;
    assign RegDst      = w_ctrl.regdst;
    assign MemtoReg    = w_ctrl.memtoreg;
    assign RegWrite    = w_ctrl.regwrite;
    assign MemRead     = w_ctrl.memread;
    assign MemWrite    = w_ctrl.memwrite;
    assign halted      = r_halted;
    assign bus_err     = r_bus_err;
    assign retired     = r_retired;
    assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a 32-bit counter build and a 4-bit counter
// build share stimulus; each instruction's expected state walk is built
// from the opcode's path through the machine and checked every cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        IorD, IRWrite, PCWrite, PCWriteCond, ALUSrcA;
    logic [1:0]  PCSrc, ALUSrcB, ALUOP;
    logic        RegDst, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        halted, bus_err;
    logic [31:0] retired;
    logic [3:0]  state_o;

    logic        b_IorD, b_IRWrite, b_PCWrite, b_PCWriteCond, b_ALUSrcA;
    logic [1:0]  b_PCSrc, b_ALUSrcB, b_ALUOP;
    logic        b_RegDst, b_MemtoReg, b_RegWrite, b_MemRead, b_MemWrite;
    logic        b_halted, b_bus_err;
    logic [3:0]  b_retired;
    logic [3:0]  b_state_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_ret = '0;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                   ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                   ST_BRANCH = 8, ST_ADDIEX = 9, ST_ADDIWB = 10, ST_JUMP = 11,
                   ST_TRAP = 15;
    localparam logic [5:0] C_LW = 6'b100011, C_SW = 6'b101011, C_R = 6'b000000,
                           C_BEQ = 6'b000100, C_ADDI = 6'b001000, C_J = 6'b000010;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .halted(halted), .bus_err(bus_err), .retired(retired), .state_o(state_o)
    );

    multicycle_control #(.CNT_W(4), .MAX_WAIT(15)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(b_IorD), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite),
        .PCWriteCond(b_PCWriteCond), .PCSrc(b_PCSrc), .ALUSrcA(b_ALUSrcA),
        .ALUSrcB(b_ALUSrcB), .ALUOP(b_ALUOP), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .MemRead(b_MemRead),
        .MemWrite(b_MemWrite), .halted(b_halted), .bus_err(b_bus_err),
        .retired(b_retired), .state_o(b_state_o)
    );

    logic [15:0] obs_str;
    assign obs_str = {IorD, IRWrite, PCWrite, PCWriteCond, PCSrc, ALUSrcA,
                      ALUSrcB, ALUOP, RegDst, MemtoReg, RegWrite, MemRead, MemWrite};

    // Strobe table: what each state asks of the datapath.
    function automatic logic [15:0] exp_str(input int st, input bit rdy);
        logic iord, irw, pcw, pcwc, srca, rdst, m2r, rw, mr, mw;
        logic [1:0] pcsrc, srcb, aluop;
        {iord, irw, pcw, pcwc, srca, rdst, m2r, rw, mr, mw} = '0;
        pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (st)
            ST_FETCH:  begin mr = 1; if (rdy) begin irw = 1; pcw = 1; srcb = 2'b01; end end
            ST_DECODE: srcb = 2'b11;
            ST_MEMADR: begin srca = 1; srcb = 2'b10; end
            ST_MEMRD:  begin mr = 1; iord = 1; end
            ST_MEMWB:  begin m2r = 1; rw = 1; end
            ST_MEMWR:  begin mw = 1; iord = 1; end
            ST_EXEC:   begin srca = 1; aluop = 2'b10; end
            ST_ALUWB:  begin rdst = 1; rw = 1; end
            ST_BRANCH: begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            ST_ADDIEX: begin srca = 1; srcb = 2'b10; end
            ST_ADDIWB: rw = 1;
            ST_JUMP:   begin pcw = 1; pcsrc = 2'b10; end
            default: ;
        endcase
        return {iord, irw, pcw, pcwc, pcsrc, srca, srcb, aluop, rdst, m2r, rw, mr, mw};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One instruction: fw stalled fetch cycles, mw stalled data cycles.
    // abort_at >= 0 stops before that path index, leaving it unretired.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int abort_at);
        int st_q[$];
        bit rd_q[$];
        bit legal;
        legal = 1'b1;
        for (int i = 0; i < fw; i++) begin st_q.push_back(ST_FETCH); rd_q.push_back(1'b0); end
        st_q.push_back(ST_FETCH);  rd_q.push_back(1'b1);
        st_q.push_back(ST_DECODE); rd_q.push_back(1'($urandom));
        case (op)
            C_LW, C_SW: begin
                st_q.push_back(ST_MEMADR); rd_q.push_back(1'($urandom));
                for (int i = 0; i <= mw; i++) begin
                    st_q.push_back((op == C_LW) ? ST_MEMRD : ST_MEMWR);
                    rd_q.push_back(i == mw);
                end
                if (op == C_LW) begin st_q.push_back(ST_MEMWB); rd_q.push_back(1'($urandom)); end
            end
            C_R:    begin st_q.push_back(ST_EXEC); st_q.push_back(ST_ALUWB);
                          rd_q.push_back(1'($urandom)); rd_q.push_back(1'($urandom)); end
            C_BEQ:  begin st_q.push_back(ST_BRANCH); rd_q.push_back(1'($urandom)); end
            C_ADDI: begin st_q.push_back(ST_ADDIEX); st_q.push_back(ST_ADDIWB);
                          rd_q.push_back(1'($urandom)); rd_q.push_back(1'($urandom)); end
            C_J:    begin st_q.push_back(ST_JUMP); rd_q.push_back(1'($urandom)); end
            default: legal = 1'b0;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            if (i == abort_at) return;
            mem_ready = rd_q[i];
            opcode    = op;
            #1;
            chk($sformatf("state op=%b i=%0d", op, i), 64'(state_o), 64'(st_q[i]));
            chk($sformatf("strobes op=%b st=%0d", op, st_q[i]), 64'(obs_str),
                64'(exp_str(st_q[i], rd_q[i])));
            chk("retired", 64'(retired), 64'(model_ret));
            chk("retired4", 64'(b_retired), 64'(model_ret[3:0]));
            chk("halted", 64'(halted), 64'd0);
            chk("bus_err", 64'(bus_err), 64'd0);
            step();
        end
        if (legal) model_ret = model_ret + 32'd1;
    endtask

    // Parked in TRAP: no strobes, flags sticky, counter frozen.
    task automatic hold_trap(input int n, input bit exp_bus);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            opcode    = 6'($urandom);
            #1;
            chk("trap state", 64'(state_o), 64'(ST_TRAP));
            chk("trap strobes", 64'(obs_str), 64'd0);
            chk("trap halted", 64'(halted), 64'd1);
            chk("trap bus_err", 64'(bus_err), 64'(exp_bus));
            chk("trap retired", 64'(retired), 64'(model_ret));
            step();
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        chk("reset strobes", 64'(obs_str), 64'd0);
        chk("reset memread", 64'(MemRead), 64'd0);
        step();
        reset     = 1'b0;
        model_ret = '0;
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = C_LW; ops[1] = C_SW; ops[2] = C_R;
        ops[3] = C_BEQ; ops[4] = C_ADDI; ops[5] = C_J;
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst state", 64'(state_o), 64'(ST_FETCH));
        chk("rst retired", 64'(retired), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);
        chk("rst bus_err", 64'(bus_err), 64'd0);
        chk("rst strobes", 64'(obs_str), 64'd0);
        reset = 1'b0;

        // lw with no waits, sw with three stalled write cycles
        run_instr(C_LW, 0, 0, -1);
        run_instr(C_SW, 0, 3, -1);
        // R-type, beq, j, addi back to back
        run_instr(C_R, 0, 0, -1);
        run_instr(C_BEQ, 0, 0, -1);
        run_instr(C_J, 0, 0, -1);
        run_instr(C_ADDI, 0, 0, -1);
        // ready arriving on the last allowed stall cycle is not an error
        run_instr(C_J, 14, 0, -1);
        run_instr(C_LW, 0, 14, -1);
        run_instr(C_SW, 14, 14, -1);

        // randomized instruction mix with short random stalls
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
        #1;
        chk("retired after mix", 64'(retired), 64'(model_ret));

        // illegal opcode traps and stays until reset
        run_instr(6'b111111, 0, 0, -1);
        hold_trap(20, 1'b0);
        do_reset();
        run_instr(C_J, 0, 0, -1);

        // fetch stalled 15 cycles -> bus error
        for (int i = 0; i < 15; i++) begin
            mem_ready = 1'b0;
            #1;
            chk("stall state", 64'(state_o), 64'(ST_FETCH));
            chk("stall strobes", 64'(obs_str), 64'(exp_str(ST_FETCH, 1'b0)));
            chk("stall bus_err", 64'(bus_err), 64'd0);
            step();
        end
        hold_trap(3, 1'b1);
        do_reset();

        // reset in the middle of a data read wait
        run_instr(C_J, 0, 0, -1);
        run_instr(C_LW, 0, 6, 5);
        do_reset();
        run_instr(C_BEQ, 0, 0, -1);

        // 4-bit counter wraps 15 -> 0 on the sixteenth retire
        do_reset();
        for (int n = 0; n < 16; n++) run_instr(C_J, 0, 0, -1);
        #1;
        chk("wrap4", 64'(b_retired), 64'd0);
        chk("ret32 16", 64'(retired), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
